mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
//  Replaces the single-cycle combinational multiply in the execute stage.
//  Execute stage launches an op with start_i; the hazard unit stalls any HI/LO read while busy_o=1.
//  Supports signed and unsigned multiply and divide, width-parametrised; mthi/mtlo write ports.
// PARAMETERS
//  DATA_W  32  operand/HI/LO width; any even value >= 4
//  CNT_W   $clog2(DATA_W)+1  iteration counter width (localparam, not overridable)
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       reset, asynchronous, active-low
//  start_i   in   1       launch op_i on a_i,b_i (sampled only in IDLE)
//  op_i      in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a_i       in   DATA_W  multiplicand / dividend (rs)
//  b_i       in   DATA_W  multiplier / divisor (rt)
//  flush_i   in   1       abort in-flight op (branch/exception squash)
//  hi_we_i   in   1       mthi: HI <= wdata_i (IDLE only)
//  lo_we_i   in   1       mtlo: LO <= wdata_i (IDLE only)
//  wdata_i   in   DATA_W  mthi/mtlo data
//  busy_o    out  1       op in flight; HI/LO not yet valid
//  done_o    out  1       one-cycle pulse: HI/LO just updated
//  hi_o      out  DATA_W  HI register (product high / remainder)
//  lo_o      out  DATA_W  LO register (product low / quotient)
// BEHAVIOUR
//  Reset: state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0; effective immediately, also mid-op.
//  FSM: IDLE -> RUN -> FIX -> IDLE. busy_o = (state != IDLE), driven from state register.
//  IDLE: on start_i & !flush_i at edge E0, latch |a|,|b| (|x| = x if unsigned op or x>=0, else -x),
//   result signs, op; counter=0; -> RUN. start_i ignored in RUN/FIX.
//  RUN: one iteration per cycle, exactly DATA_W cycles (edges E1..E_DATA_W), then -> FIX.
//   Multiply: shift-add over 2*DATA_W accumulator, one multiplier bit per cycle, LSB first.
//   Divide: restoring, one quotient bit per cycle, MSB first; remainder DATA_W+1 bits internally.
//  FIX (edge E_DATA_W+1): apply sign correction, write HI/LO, done_o=1 for that cycle, -> IDLE.
//   Total: busy_o high DATA_W+1 cycles; new HI/LO and done_o visible after edge E_DATA_W+1.
//  Sign rules (signed ops only): product negated (2*DATA_W two's complement) if signs differ;
//   quotient negated if signs differ; remainder takes dividend sign. Unsigned ops: no correction.
//  Divide by zero (b_i=0): full latency; LO = all ones, HI = a_i (original dividend, unmodified).
//  Signed MIN / -1: LO = MIN, HI = 0 (falls out of magnitude algorithm; no trap).
//  flush_i: in RUN/FIX -> IDLE at next edge, HI/LO unchanged, no done_o; in IDLE blocks start_i.
//   flush_i in FIX cycle wins over result write.
//  hi_we_i/lo_we_i: honoured only in IDLE; ignored while busy_o=1 (pipeline stalls mthi/mtlo).
//   Write + start_i same IDLE cycle: write applied now; op result overwrites at its FIX.
//  done_o deasserts the cycle after it is raised; hi_o/lo_o are plain register outputs.
//  Arithmetic: all internal widths sized from DATA_W; no truncation of 2*DATA_W product.
// TESTING (DATA_W=32; "cycle n" = n-th rising edge after the start edge)
//  MULT a=0xFFFFFFFD(-3) b=7 -> busy 33 cycles; cycle 33: done_o=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DIVU 100/7 -> LO=14, HI=2.
//  DIV a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, done_o at cycle 33.
//  MULT running, flush_i at cycle 10 -> busy_o=0 after cycle 11, no done_o, HI/LO keep prior values;
//   start_i pulsed at cycle 5 of a run is ignored (single done_o).
//  mtlo 0x1234 while busy -> LO unchanged; in IDLE -> LO=0x1234 next edge; rst_n low at cycle 20
//   -> busy_o, HI, LO = 0 immediately; later start runs normally.

Source files
------------

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the execute stage and the iterative
// multiply/divide unit.
//   master (execute stage) drives: start_i, op_i, a_i, b_i, flush_i,
//                                  hi_we_i, lo_we_i, wdata_i
//   slave  (mdu_iter)      drives: busy_o, done_o, hi_o, lo_o
interface mdu_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic              flush_i;
  logic              hi_we_i;
  logic              lo_we_i;
  logic [DATA_W-1:0] wdata_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i, hi_we_i, lo_we_i, wdata_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i, hi_we_i, lo_we_i, wdata_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO result registers.
// An op runs on operand magnitudes (shift-add multiply LSB first, restoring
// divide MSB first), one bit per cycle for DATA_W cycles, then a single FIX
// cycle applies the sign correction and writes HI/LO.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mdu_if.slave: start_i/op_i/a_i/b_i launch, flush_i abort,
//          hi_we_i/lo_we_i/wdata_i mthi/mtlo, busy_o/done_o/hi_o/lo_o status
//   op_i: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
module mdu_iter #(
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, nextState;

  logic [CNT_W-1:0]    cnt;
  logic                doneReg;
  logic [DATA_W-1:0]   hiReg, loReg;

  // Operation context captured at launch.
  logic                isDiv;
  logic                negRes;    // negate product / quotient
  logic                negRem;    // remainder takes dividend sign
  logic                divZero;
  // Multiply: opB = |a|, acc = {partial high, multiplier shifting out}.
  // Divide:   opB = |b|, acc low half = dividend shifting out / quotient in.
  logic [DATA_W-1:0]   opB;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     rem;

  logic                launch;
  logic [DATA_W-1:0]   absA, absB;
  logic                aNeg, bNeg, isSigned;

  logic [DATA_W:0]     mulSum;
  logic [DATA_W:0]     divShift, divDiff;
  logic                divGe;

  logic [2*DATA_W-1:0] prodFix;
  logic [DATA_W-1:0]   quoFix, remFix;
  logic [DATA_W-1:0]   hiFix, loFix;

  assign launch   = (state == IDLE) && bus.start_i && !bus.flush_i;
  assign isSigned = ~bus.op_i[0];
  assign aNeg     = isSigned & bus.a_i[DATA_W-1];
  assign bNeg     = isSigned & bus.b_i[DATA_W-1];
  assign absA     = aNeg ? -bus.a_i : bus.a_i;
  assign absB     = bNeg ? -bus.b_i : bus.b_i;

  // One shift-add step: add multiplicand to the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mulSum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opB : '0)};

  // One restoring-divide step: bring in the next dividend bit and subtract
  // the divisor if it fits.
  assign divShift = {rem[DATA_W-1:0], acc[DATA_W-1]};
  assign divDiff  = divShift - {1'b0, opB};
  assign divGe    = (divShift >= {1'b0, opB});

  // Sign correction. With a zero divisor the magnitude algorithm leaves
  // rem = |a|, so restoring the dividend sign gives back the original a_i.
  assign prodFix  = negRes ? -acc : acc;
  assign quoFix   = negRes ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign remFix   = negRem ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hiFix = prodFix[2*DATA_W-1:DATA_W];
    loFix = prodFix[DATA_W-1:0];
    if (isDiv) begin
      hiFix = remFix;
      loFix = divZero ? '1 : quoFix;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // the pre-edge values of its inputs, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (launch) nextState = RUN;
      RUN:     if (bus.flush_i)                       nextState = IDLE;
               else if (cnt == CNT_W'(DATA_W - 1))    nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Counter, done pulse and architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      doneReg <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      cnt     <= (state == RUN && !bus.flush_i) ? cnt + 1'b1 : '0;
      // A flush in the FIX cycle wins over the result write.
      doneReg <= (state == FIX) && !bus.flush_i;
      if (state == IDLE) begin
        if (bus.hi_we_i) hiReg <= bus.wdata_i;
        if (bus.lo_we_i) loReg <= bus.wdata_i;
      end else if (state == FIX && !bus.flush_i) begin
        hiReg <= hiFix;
        loReg <= loFix;
      end
    end
  end

  // Datapath.
  // NOTE: these registers have no reset; all of them are loaded at launch
  // before any of them is consumed, so reset would only add fanout.
  always_ff @(posedge clk) begin
    if (launch) begin
      isDiv   <= bus.op_i[1];
      negRes  <= aNeg ^ bNeg;
      negRem  <= aNeg;
      divZero <= (bus.b_i == '0);
      opB     <= bus.op_i[1] ? absB : absA;
      acc     <= {{DATA_W{1'b0}}, (bus.op_i[1] ? absA : absB)};
      rem     <= '0;
    end else if (state == RUN) begin
      if (isDiv) begin
        acc[DATA_W-1:0] <= {acc[DATA_W-2:0], divGe};
        rem             <= divGe ? divDiff : divShift;
      end else begin
        acc <= {mulSum, acc[DATA_W-1:1]};
      end
    end
  end

  assign bus.busy_o = (state != IDLE);
  assign bus.done_o = doneReg;
  assign bus.hi_o   = hiReg;
  assign bus.lo_o   = loReg;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter at DATA_W=32.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mdu_iter;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  mdu_if #(.DATA_W(W)) bus();

  mdu_iter #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a launch for the edge E0; returns 1 unit after E0 with start low.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    tick();
    bus.start_i = 1'b0;
  endtask

  // Bounded wait for done_o; reports the edge number after E0 (or -1) and
  // how many samples from E0 onward showed busy_o high.
  task automatic wait_done(output int doneEdge, output int busyCycles);
    doneEdge   = -1;
    busyCycles = bus.busy_o ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.busy_o) busyCycles++;
      if (bus.done_o) begin
        doneEdge = n;
        break;
      end
    end
  endtask

  task automatic write_hilo(input logic [W-1:0] hi, input logic [W-1:0] lo);
    bus.hi_we_i = 1'b1; bus.wdata_i = hi; tick(); bus.hi_we_i = 1'b0;
    bus.lo_we_i = 1'b1; bus.wdata_i = lo; tick(); bus.lo_we_i = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [1:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] expHi, input logic [W-1:0] expLo);
    int de, bc;
    launch(op, a, b);
    wait_done(de, bc);
    compared++; if (de !== 33) begin mismatched++; $display("FAIL %s done_edge: got %0d expected 33", name, de); end
    compared++; if (bus.hi_o !== expHi) begin mismatched++; $display("FAIL %s hi: got %h expected %h", name, bus.hi_o, expHi); end
    compared++; if (bus.lo_o !== expLo) begin mismatched++; $display("FAIL %s lo: got %h expected %h", name, bus.lo_o, expLo); end
  endtask

  task automatic test_reset();
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL reset busy: got %b expected 0", bus.busy_o); end
    compared++; if (bus.done_o !== 1'b0) begin mismatched++; $display("FAIL reset done: got %b expected 0", bus.done_o); end
    compared++; if (bus.hi_o !== '0) begin mismatched++; $display("FAIL reset hi: got %h expected 0", bus.hi_o); end
    compared++; if (bus.lo_o !== '0) begin mismatched++; $display("FAIL reset lo: got %h expected 0", bus.lo_o); end
  endtask

  task automatic test_mult();
    int de, bc;
    launch(MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(de, bc);
    compared++; if (de !== 33) begin mismatched++; $display("FAIL mult done_edge: got %0d expected 33", de); end
    compared++; if (bc !== 33) begin mismatched++; $display("FAIL mult busy_cycles: got %0d expected 33", bc); end
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL mult busy_at_done: got %b expected 0", bus.busy_o); end
    compared++; if (bus.hi_o !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mult hi: got %h expected ffffffff", bus.hi_o); end
    compared++; if (bus.lo_o !== 32'hFFFF_FFEB) begin mismatched++; $display("FAIL mult lo: got %h expected ffffffeb", bus.lo_o); end
    tick();
    compared++; if (bus.done_o !== 1'b0) begin mismatched++; $display("FAIL mult done_pulse: got %b expected 0", bus.done_o); end
  endtask

  task automatic test_multu();
    run_and_check("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_and_check("multu_small", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    run_and_check("mult_pos", MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
  endtask

  task automatic test_divide();
    run_and_check("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_and_check("div_neg_dividend", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_and_check("div_neg_divisor", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_and_check("div_min_by_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    run_and_check("divu_by_zero", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_and_check("div_neg_by_zero", DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
  endtask

  task automatic test_flush_run();
    int doneCnt = 0;
    write_hilo(32'hAAAA_0000, 32'h0000_BBBB);
    launch(MULT, 32'd5, 32'd5);
    repeat (10) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL flush_run busy: got %b expected 0", bus.busy_o); end
    for (int n = 0; n < 40; n++) begin
      if (bus.done_o) doneCnt++;
      tick();
    end
    compared++; if (doneCnt !== 0) begin mismatched++; $display("FAIL flush_run done_count: got %0d expected 0", doneCnt); end
    compared++; if (bus.hi_o !== 32'hAAAA_0000) begin mismatched++; $display("FAIL flush_run hi: got %h expected aaaa0000", bus.hi_o); end
    compared++; if (bus.lo_o !== 32'h0000_BBBB) begin mismatched++; $display("FAIL flush_run lo: got %h expected 0000bbbb", bus.lo_o); end
  endtask

  task automatic test_flush_fix();
    write_hilo(32'h0000_0011, 32'h0000_0022);
    launch(DIVU, 32'd100, 32'd7);
    repeat (32) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL flush_fix busy: got %b expected 0", bus.busy_o); end
    compared++; if (bus.done_o !== 1'b0) begin mismatched++; $display("FAIL flush_fix done: got %b expected 0", bus.done_o); end
    compared++; if (bus.hi_o !== 32'h11) begin mismatched++; $display("FAIL flush_fix hi: got %h expected 00000011", bus.hi_o); end
    compared++; if (bus.lo_o !== 32'h22) begin mismatched++; $display("FAIL flush_fix lo: got %h expected 00000022", bus.lo_o); end
    // A flush in IDLE blocks a simultaneous start.
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = MULTU;
    tick();
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL flush_idle busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_back_to_back_start();
    int de = -1;
    int doneCnt = 0;
    launch(MULTU, 32'd3, 32'd4);
    repeat (5) tick();
    bus.start_i = 1'b1; bus.op_i = DIVU; bus.a_i = 32'd100; bus.b_i = 32'd7;
    tick();
    bus.start_i = 1'b0;
    for (int n = 7; n <= 45; n++) begin
      tick();
      if (bus.done_o) begin de = n; break; end
    end
    compared++; if (de !== 33) begin mismatched++; $display("FAIL ignore_start done_edge: got %0d expected 33", de); end
    compared++; if (bus.lo_o !== 32'd12) begin mismatched++; $display("FAIL ignore_start lo: got %h expected 0000000c", bus.lo_o); end
    compared++; if (bus.hi_o !== 32'd0) begin mismatched++; $display("FAIL ignore_start hi: got %h expected 00000000", bus.hi_o); end
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.done_o) doneCnt++;
    end
    compared++; if (doneCnt !== 0) begin mismatched++; $display("FAIL ignore_start extra_done: got %0d expected 0", doneCnt); end
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL ignore_start busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_mthi_mtlo();
    int de, bc;
    bus.lo_we_i = 1'b1; bus.wdata_i = 32'h1234;
    tick();
    bus.lo_we_i = 1'b0;
    compared++; if (bus.lo_o !== 32'h1234) begin mismatched++; $display("FAIL mtlo_idle lo: got %h expected 00001234", bus.lo_o); end
    bus.hi_we_i = 1'b1; bus.wdata_i = 32'hABCD;
    tick();
    bus.hi_we_i = 1'b0;
    compared++; if (bus.hi_o !== 32'hABCD) begin mismatched++; $display("FAIL mthi_idle hi: got %h expected 0000abcd", bus.hi_o); end
    launch(MULTU, 32'd2, 32'd3);
    repeat (3) tick();
    bus.lo_we_i = 1'b1; bus.wdata_i = 32'h5555;
    tick();
    bus.lo_we_i = 1'b0;
    compared++; if (bus.lo_o !== 32'h1234) begin mismatched++; $display("FAIL mtlo_busy lo: got %h expected 00001234", bus.lo_o); end
    wait_done(de, bc);
    compared++; if (bus.lo_o !== 32'd6) begin mismatched++; $display("FAIL mtlo_busy result_lo: got %h expected 00000006", bus.lo_o); end
    // Write and start in the same IDLE cycle: write lands now, result later.
    bus.lo_we_i = 1'b1; bus.wdata_i = 32'h9999;
    launch(MULTU, 32'h10, 32'h10);
    bus.lo_we_i = 1'b0;
    compared++; if (bus.lo_o !== 32'h9999) begin mismatched++; $display("FAIL mtlo_start lo: got %h expected 00009999", bus.lo_o); end
    wait_done(de, bc);
    compared++; if (bus.lo_o !== 32'h100) begin mismatched++; $display("FAIL mtlo_start result_lo: got %h expected 00000100", bus.lo_o); end
  endtask

  task automatic test_reset_mid_op();
    write_hilo(32'hDEAD, 32'hBEEF);
    launch(MULT, 32'd3, 32'd3);
    repeat (20) tick();
    #1 rst_n = 1'b0;
    #1;
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_mid busy: got %b expected 0", bus.busy_o); end
    compared++; if (bus.hi_o !== '0) begin mismatched++; $display("FAIL reset_mid hi: got %h expected 0", bus.hi_o); end
    compared++; if (bus.lo_o !== '0) begin mismatched++; $display("FAIL reset_mid lo: got %h expected 0", bus.lo_o); end
    tick();
    rst_n = 1'b1;
    run_and_check("after_reset_divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.op_i = MULT; bus.a_i = '0; bus.b_i = '0;
    bus.flush_i = 1'b0; bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0; bus.wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_mult();
    test_multu();
    test_divide();
    test_div_zero();
    test_flush_run();
    test_flush_fix();
    test_back_to_back_start();
    test_mthi_mtlo();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
